// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter
//    Two-requester round-robin arbiter in front of a single AHB-Lite GPIO
//    slave. Only one transfer is in flight at a time: an address phase is
//    followed by a data phase, and completion is reported one cycle later
//    together with the next arbitration.
//
//    state | meaning
//    ------+-------------------------------------------------------------
//    IDLE  | no transfer; completion pulse of the previous transfer shows
//          | here; a request sampled here is granted
//    ADDR  | address phase, GNTx high for the owner, NONSEQ on the bus
//    DATA  | data phase, waiting for HREADYOUT or the wait-cycle timeout
//
// Ports
//    HCLK, HRESET               clock, synchronous active-high reset
//    REQx/WEx/ADDRx/WDATAx      requester x transfer request (x = 0, 1)
//    GNTx, DONEx                one-cycle grant / completion pulses
//    ERR, RDATA                 completion status and read data, valid with DONEx
//    HSEL/HTRANS/HWRITE/HADDR/HWDATA/HREADY   AHB-Lite master side
//    HRDATA, HREADYOUT          AHB-Lite slave response
module gpio_bus_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic        WE0,
   input  logic        WE1,
   input  logic [31:0] ADDR0,
   input  logic [31:0] ADDR1,
   input  logic [31:0] WDATA0,
   input  logic [31:0] WDATA1,
   output logic        GNT0,
   output logic        GNT1,
   output logic        DONE0,
   output logic        DONE1,
   output logic        ERR,
   output logic [31:0] RDATA,
   output logic        HSEL,
   output logic        HWRITE,
   output logic [1:0]  HTRANS,
   output logic [31:0] HADDR,
   output logic [31:0] HWDATA,
   output logic        HREADY,
   input  logic [31:0] HRDATA,
   input  logic        HREADYOUT
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        req_any;
   logic        winner;
   logic        last_gnt;
   logic        owner;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [7:0]  wait_cnt;
   logic        gnt0_q;
   logic        gnt1_q;
   logic        done0_q;
   logic        done1_q;
   logic        err_q;
   logic [31:0] rdata_q;
   logic        timed_out;

   assign req_any   = REQ0 | REQ1;
   // On a tie the requester not granted last time wins; otherwise the lone
   // requester wins (REQ1 alone selects 1, REQ0 alone selects 0).
   assign winner    = (REQ0 & REQ1) ? ~last_gnt : REQ1;
   assign timed_out = !HREADYOUT && (wait_cnt == TIMEOUT_CNT);

   // state register
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req_any) begin
               state_nxt = ST_ADDR;
            end
         end
         ST_ADDR: begin
            state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (HREADYOUT || timed_out) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // output logic
   always_comb begin
      HSEL   = 1'b0;
      HTRANS = HTRANS_IDLE;
      HWDATA = 32'h0;
      case (state)
         ST_ADDR: begin
            HSEL   = 1'b1;
            HTRANS = HTRANS_NONSEQ;
         end
         ST_DATA: begin
            HWDATA = we_q ? wdata_q : 32'h0;
         end
         default: begin
            HSEL = 1'b0;
         end
      endcase
   end

   assign HADDR  = addr_q;
   assign HWRITE = we_q;
   assign HREADY = HREADYOUT;
   assign GNT0   = gnt0_q;
   assign GNT1   = gnt1_q;
   assign DONE0  = done0_q;
   assign DONE1  = done1_q;
   assign ERR    = err_q;
   assign RDATA  = rdata_q;

   // Transfer datapath: request latch, wait counter, grant/completion pulses.
   // The fairness pointer moves on grant so a timed-out transfer still counts
   // as that requester's turn.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         last_gnt <= 1'b1;
         owner    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         wait_cnt <= 8'd0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         err_q   <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (req_any) begin
                  owner    <= winner;
                  last_gnt <= winner;
                  we_q     <= winner ? WE1    : WE0;
                  addr_q   <= winner ? ADDR1  : ADDR0;
                  wdata_q  <= winner ? WDATA1 : WDATA0;
                  gnt0_q   <= ~winner;
                  gnt1_q   <= winner;
               end
            end
            ST_ADDR: begin
               wait_cnt <= 8'd1;
            end
            ST_DATA: begin
               if (HREADYOUT) begin
                  done0_q  <= ~owner;
                  done1_q  <= owner;
                  wait_cnt <= 8'd0;
                  if (!we_q) begin
                     rdata_q <= HRDATA;
                  end
               end else if (timed_out) begin
                  done0_q  <= ~owner;
                  done1_q  <= owner;
                  err_q    <= 1'b1;
                  rdata_q  <= 32'h0;
                  wait_cnt <= 8'd0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: begin
               wait_cnt <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter: a per-cycle vector table for the
// basic write/read/arbitration flow, then hand sequences for wait-state
// timeout, reset during a transfer and back-to-back round-robin.
module tb_gpio_bus_arbiter;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
   logic [31:0] ADDR0 = '0, ADDR1 = '0, WDATA0 = '0, WDATA1 = '0;
   logic        GNT0, GNT1, DONE0, DONE1, ERR;
   logic [31:0] RDATA;
   logic        HSEL, HWRITE, HREADY;
   logic [1:0]  HTRANS;
   logic [31:0] HADDR, HWDATA;
   logic [31:0] HRDATA = '0;
   logic        HREADYOUT = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   always #5 HCLK = ~HCLK;

   gpio_bus_arbiter #(.TIMEOUT(16)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
      .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
      .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
      .ERR(ERR), .RDATA(RDATA),
      .HSEL(HSEL), .HWRITE(HWRITE), .HTRANS(HTRANS), .HADDR(HADDR),
      .HWDATA(HWDATA), .HREADY(HREADY),
      .HRDATA(HRDATA), .HREADYOUT(HREADYOUT)
   );

   typedef struct {
      logic        rst, req0, req1, we0, we1;
      logic [31:0] addr0, addr1, wdata0, wdata1, hrdata;
      logic        hro;
      logic        gnt0, gnt1, done0, done1, err;
      logic [31:0] rdata;
      logic        hsel;
      logic [1:0]  htrans;
      logic        hwrite;
      logic [31:0] haddr, hwdata;
   } vec_t;

   vec_t vt[17];

   function automatic vec_t mk(
      input logic [31:0] rst, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input logic [31:0] hrdata, hro, gnt0, gnt1, done0, done1, err, rdata,
      input logic [31:0] hsel, htrans, hwrite, haddr, hwdata);
      vec_t v;
      v.rst = rst[0];     v.req0 = req0[0];   v.req1 = req1[0];
      v.we0 = we0[0];     v.we1 = we1[0];
      v.addr0 = addr0;    v.addr1 = addr1;    v.wdata0 = wdata0;
      v.wdata1 = wdata1;  v.hrdata = hrdata;  v.hro = hro[0];
      v.gnt0 = gnt0[0];   v.gnt1 = gnt1[0];   v.done0 = done0[0];
      v.done1 = done1[0]; v.err = err[0];     v.rdata = rdata;
      v.hsel = hsel[0];   v.htrans = htrans[1:0]; v.hwrite = hwrite[0];
      v.haddr = haddr;    v.hwdata = hwdata;
      return v;
   endfunction

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string nm);
      chk({nm, " gnt0"},   32'(GNT0),   0);
      chk({nm, " gnt1"},   32'(GNT1),   0);
      chk({nm, " done0"},  32'(DONE0),  0);
      chk({nm, " done1"},  32'(DONE1),  0);
      chk({nm, " err"},    32'(ERR),    0);
      chk({nm, " rdata"},  RDATA,       0);
      chk({nm, " hsel"},   32'(HSEL),   0);
      chk({nm, " htrans"}, 32'(HTRANS), 0);
      chk({nm, " hwrite"}, 32'(HWRITE), 0);
      chk({nm, " haddr"},  HADDR,       0);
      chk({nm, " hwdata"}, HWDATA,      0);
   endtask

   // One complete transfer from IDLE. ready_after = number of DATA cycles with
   // HREADYOUT low before it rises; exp_cyc = edge (counted from the request
   // edge) at which DONE must appear.
   task automatic xfer(input string nm, input int who, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] hrdata, input int ready_after,
                       input int exp_cyc, input logic exp_err,
                       input logic [31:0] exp_rdata);
      int k;
      REQ0 = (who == 0); REQ1 = (who == 1);
      WE0 = we; WE1 = we; ADDR0 = addr; ADDR1 = addr;
      WDATA0 = wdata; WDATA1 = wdata; HRDATA = hrdata; HREADYOUT = 1'b0;
      step();
      k = 1;
      chk({nm, " gnt0"}, 32'(GNT0), 32'(who == 0));
      chk({nm, " gnt1"}, 32'(GNT1), 32'(who == 1));
      REQ0 = 1'b0; REQ1 = 1'b0;
      while (k < 40) begin
         if (DONE0 || DONE1) break;
         HREADYOUT = (k >= 2) && (k - 1 > ready_after);
         step();
         k++;
      end
      chk({nm, " done cycle"}, 32'(k), 32'(exp_cyc));
      chk({nm, " done0"}, 32'(DONE0), 32'(who == 0));
      chk({nm, " done1"}, 32'(DONE1), 32'(who == 1));
      chk({nm, " err"}, 32'(ERR), 32'(exp_err));
      chk({nm, " rdata"}, RDATA, exp_rdata);
      HREADYOUT = 1'b1;
   endtask

   initial begin
      // rst req0 req1 we0 we1 addr0 addr1 wdata0 wdata1 hrdata hro | gnt0 gnt1 done0 done1 err rdata hsel htrans hwrite haddr hwdata
      vt[0]  = mk(1,0,0,0,0, 0,0,0,0, 0,1,  0,0,0,0,0, 0, 0,0,0, 0,0);
      vt[1]  = mk(0,1,0,1,0, 32'h4,0,32'h0001_FFFF,0, 0,1,  1,0,0,0,0, 0, 1,2,1, 32'h4,0);
      vt[2]  = mk(0,0,0,0,0, 0,0,0,0, 0,1,  0,0,0,0,0, 0, 0,0,1, 32'h4,32'h0001_FFFF);
      vt[3]  = mk(0,0,0,0,0, 0,0,0,0, 0,1,  0,0,1,0,0, 0, 0,0,1, 32'h4,0);
      vt[4]  = mk(0,0,0,0,0, 0,0,0,0, 0,1,  0,0,0,0,0, 0, 0,0,1, 32'h4,0);
      vt[5]  = mk(0,0,1,0,0, 0,32'h0,0,32'h77, 0,1,  0,1,0,0,0, 0, 1,2,0, 0,0);
      vt[6]  = mk(0,0,0,0,0, 0,0,0,0, 0,0,  0,0,0,0,0, 0, 0,0,0, 0,0);
      vt[7]  = mk(0,0,0,0,0, 0,0,0,0, 0,0,  0,0,0,0,0, 0, 0,0,0, 0,0);
      vt[8]  = mk(0,0,0,0,0, 0,0,0,0, 0,0,  0,0,0,0,0, 0, 0,0,0, 0,0);
      vt[9]  = mk(0,0,0,0,0, 0,0,0,0, 0,0,  0,0,0,0,0, 0, 0,0,0, 0,0);
      vt[10] = mk(0,0,0,0,0, 0,0,0,0, 32'h0000_A5A5,1,  0,0,0,1,0, 32'h0000_A5A5, 0,0,0, 0,0);
      vt[11] = mk(0,1,1,1,0, 32'h10,32'h20,32'hDEAD_BEEF,0, 32'h1234,1,  1,0,0,0,0, 32'h0000_A5A5, 1,2,1, 32'h10,0);
      vt[12] = mk(0,0,1,0,0, 0,32'h20,0,0, 32'h1234,1,  0,0,0,0,0, 32'h0000_A5A5, 0,0,1, 32'h10,32'hDEAD_BEEF);
      vt[13] = mk(0,0,1,0,0, 0,32'h20,0,0, 32'h1234,1,  0,0,1,0,0, 32'h0000_A5A5, 0,0,1, 32'h10,0);
      vt[14] = mk(0,0,1,0,0, 0,32'h20,0,0, 0,1,  0,1,0,0,0, 32'h0000_A5A5, 1,2,0, 32'h20,0);
      vt[15] = mk(0,0,0,0,0, 0,0,0,0, 32'h5555_0000,1,  0,0,0,0,0, 32'h0000_A5A5, 0,0,0, 32'h20,0);
      vt[16] = mk(0,0,0,0,0, 0,0,0,0, 32'h5555_0000,1,  0,0,0,1,0, 32'h5555_0000, 0,0,0, 32'h20,0);

      for (int i = 0; i < 17; i++) begin
         HRESET = vt[i].rst; REQ0 = vt[i].req0; REQ1 = vt[i].req1;
         WE0 = vt[i].we0; WE1 = vt[i].we1;
         ADDR0 = vt[i].addr0; ADDR1 = vt[i].addr1;
         WDATA0 = vt[i].wdata0; WDATA1 = vt[i].wdata1;
         HRDATA = vt[i].hrdata; HREADYOUT = vt[i].hro;
         step();
         chk($sformatf("row%0d gnt0", i),   32'(GNT0),   32'(vt[i].gnt0));
         chk($sformatf("row%0d gnt1", i),   32'(GNT1),   32'(vt[i].gnt1));
         chk($sformatf("row%0d done0", i),  32'(DONE0),  32'(vt[i].done0));
         chk($sformatf("row%0d done1", i),  32'(DONE1),  32'(vt[i].done1));
         chk($sformatf("row%0d err", i),    32'(ERR),    32'(vt[i].err));
         chk($sformatf("row%0d rdata", i),  RDATA,       vt[i].rdata);
         chk($sformatf("row%0d hsel", i),   32'(HSEL),   32'(vt[i].hsel));
         chk($sformatf("row%0d htrans", i), 32'(HTRANS), 32'(vt[i].htrans));
         chk($sformatf("row%0d hwrite", i), 32'(HWRITE), 32'(vt[i].hwrite));
         chk($sformatf("row%0d haddr", i),  HADDR,       vt[i].haddr);
         chk($sformatf("row%0d hwdata", i), HWDATA,      vt[i].hwdata);
         chk($sformatf("row%0d hready", i), 32'(HREADY), 32'(vt[i].hro));
      end

      // wait-state handling around the 16-cycle timeout
      xfer("timeout",     0, 1'b0, 32'h8,  0, 32'h0BAD, 1000, 18, 1'b1, 32'h0);
      xfer("ready_at_16", 1, 1'b0, 32'hC,  0, 32'hCAFE, 15,   18, 1'b0, 32'hCAFE);
      xfer("after_to",    0, 1'b0, 32'h0,  0, 32'h1357, 0,    3,  1'b0, 32'h1357);
      xfer("low_16",      1, 1'b0, 32'h4,  0, 32'h2468, 16,   18, 1'b1, 32'h0);

      // reset while in the data phase
      REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 32'h30; WDATA0 = 32'h99; HREADYOUT = 1'b0;
      step();
      REQ0 = 1'b0;
      step();
      step();
      HRESET = 1'b1;
      step();
      chk_idle_outputs("mid_reset");
      HRESET = 1'b0; HREADYOUT = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mid_reset no done0", 32'(DONE0), 0);
         chk("mid_reset no done1", 32'(DONE1), 0);
      end
      xfer("post_reset", 0, 1'b1, 32'h30, 32'h99, 32'hFFFF, 0, 3, 1'b0, 32'h0);

      // both requesters held from reset: grants alternate every 3 cycles
      HRESET = 1'b1;
      step();
      HRESET = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1; HREADYOUT = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         chk($sformatf("rr c%0d gnt0", k), 32'(GNT0),
             32'((k % 3 == 1) && ((k / 3) % 2 == 0)));
         chk($sformatf("rr c%0d gnt1", k), 32'(GNT1),
             32'((k % 3 == 1) && ((k / 3) % 2 == 1)));
      end
      REQ0 = 1'b0; REQ1 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gpio_bus_arbiter.md
GPIO_BUS_ARBITER -- requirements
Module: gpio_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning: max DATA-phase cycles waiting for HREADYOUT before the transfer is aborted; legal range 2..255.
REQ-002 HCLK  input  1  single clock; all state updates on rising edge.
REQ-003 HRESET  input  1  reset, synchronous and active-high.
REQ-004 REQ0, REQ1  input  1 each  transfer request from requester 0 / 1; level-sensitive.
REQ-005 WE0, WE1  input  1 each  1 = write, 0 = read.
REQ-006 ADDR0, ADDR1  input  32 each  target GPIO register address.
REQ-007 WDATA0, WDATA1  input  32 each  write data.
REQ-008 GNT0, GNT1  output  1 each  one-cycle grant pulse.
REQ-009 DONE0, DONE1  output  1 each  one-cycle completion pulse.
REQ-010 ERR  output  1  valid with DONEx; 1 = timeout abort.
REQ-011 RDATA  output  32  read data; valid with DONEx.
REQ-012 HSEL, HWRITE  output  1 each  AHB-Lite slave select / direction.
REQ-013 HTRANS  output  2  AHB-Lite transfer type.
REQ-014 HADDR, HWDATA  output  32 each  AHB-Lite address / write data.
REQ-015 HREADY  output  1  bus ready to slave.
REQ-016 HRDATA  input  32  slave read data.
REQ-017 HREADYOUT  input  1  slave ready.

Function
REQ-018 FSM states IDLE, ADDR, DATA; exactly one transfer in flight; no pipelining.
REQ-019 IDLE: if REQ0|REQ1 sampled high, select winner, latch its WE/ADDR/WDATA, go to ADDR; else stay IDLE.
REQ-020 Arbitration round-robin: both requesting -> requester not granted most recently wins; single requester wins unconditionally.
REQ-021 GNTx is registered: high for exactly the ADDR cycle of requester x's transfer; never both high.
REQ-022 ADDR: HSEL=1, HTRANS=2'b10 (NONSEQ), HADDR/HWRITE = latched values; go to DATA next cycle unconditionally.
REQ-023 DATA: HSEL=0, HTRANS=2'b00, HWDATA = latched WDATA (0 for reads); HADDR/HWRITE held.
REQ-024 HREADY SHALL equal HREADYOUT combinationally in every state.
REQ-025 DATA with HREADYOUT=1: capture HRDATA into RDATA (reads only), go IDLE; DONEx=1, ERR=0 on the following cycle.
REQ-026 DATA wait counter starts at 1 on DATA entry and increments each cycle HREADYOUT=0; when it equals TIMEOUT with HREADYOUT=0: go IDLE, next cycle DONEx=1, ERR=1, RDATA=0.
REQ-027 DONE/ERR/RDATA cycle coincides with IDLE; arbitration occurs in that same cycle; minimum 3 cycles per transfer.
REQ-028 Requesters hold REQ/WE/ADDR/WDATA stable until GNT; REQ still high in the GNT cycle's following IDLE is a new request (back-to-back).
REQ-029 RDATA holds its value between completions; write completions leave RDATA unchanged.
REQ-030 Round-robin pointer updates on grant, not on completion; timeout does not affect fairness.

Reset
REQ-031 HRESET high at a clock edge: state IDLE, counter 0, last-grant pointer = requester 1 (requester 0 wins first tie).
REQ-032 Reset values: GNTx=0, DONEx=0, ERR=0, RDATA=0, HSEL=0, HTRANS=2'b00, HWRITE=0, HADDR=0, HWDATA=0.
REQ-033 Reset mid-transfer abandons it: no DONE issued, outputs at reset values from the next cycle.

Verification
REQ-034 REQ0=1, WE0=1, ADDR0=0x04, WDATA0=0x0001_FFFF, HREADYOUT=1 -> GNT0 cycle 1 with HTRANS=2'b10, HADDR=0x04; HWDATA=0x0001_FFFF cycle 2; DONE0=1, ERR=0 cycle 3.
REQ-035 REQ0 and REQ1 both held high from reset, HREADYOUT=1 -> grants alternate 0,1,0,1; one grant every 3 cycles.
REQ-036 Read REQ1, ADDR1=0x00, HREADYOUT low 3 cycles, HRDATA=0x0000_A5A5 -> DATA lasts 4 cycles; DONE1=1, RDATA=0x0000_A5A5.
REQ-037 TIMEOUT=16, HREADYOUT held 0 -> DONE0=1, ERR=1, RDATA=0 after 16 DATA cycles; next request is served normally.
REQ-038 HRESET asserted during DATA -> next cycle all outputs at reset values, no DONE; subsequent REQ0 completes normally.
